// File: rtl/ipif_pkg.sv
// Shared types and helpers for the IPIF AXI4-Lite register bank.
// Holds response codes, the read/write FSM states and the byte-strobe merge.
package ipif_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Widest data bus supported; narrower buses zero-extend into the merge helper.
  localparam int MAX_W = 64;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0]   old,
                                                  input logic [MAX_W-1:0]   wdata,
                                                  input logic [MAX_W/8-1:0] wstrb);
    logic [MAX_W-1:0] res;
    res = old;
    for (int b = 0; b < MAX_W/8; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ipif_axi_lite_regs.sv
// AXI4-Lite slave register bank: N_REG control words out on params_from_bus,
// read-only words sourced from params_to_bus, one-cycle write strobes per register.
module ipif_axi_lite_regs
  import ipif_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_REG              = 2,
  parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] REG_RESET = '0,
  parameter logic [N_REG-1:0] RO_MASK = '0
) (
  input  logic                                  bus_clk,
  input  logic                                  bus_rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic                                  s_axi_awvalid,
  output logic                                  s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                                  s_axi_wvalid,
  output logic                                  s_axi_wready,
  output logic [1:0]                            s_axi_bresp,
  output logic                                  s_axi_bvalid,
  input  logic                                  s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]         s_axi_araddr,
  input  logic                                  s_axi_arvalid,
  output logic                                  s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                            s_axi_rresp,
  output logic                                  s_axi_rvalid,
  input  logic                                  s_axi_rready,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   params_from_bus,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]   params_to_bus,
  output logic [N_REG-1:0]                      wr_pulse
);

  localparam int W        = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int ADDR_LSB = $clog2(W/8);

  // Keeps all readies low until the first edge after reset is released.
  logic init_q;

  logic            aw_held_q, aw_held_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic            w_held_q, w_held_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [W/8-1:0]  wstrb_q, wstrb_d;
  wr_state_t       wr_state_q, wr_state_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [N_REG-1:0] wr_pulse_q, wr_pulse_d;
  logic [N_REG*W-1:0] regs_q, regs_d;

  rd_state_t       rd_state_q, rd_state_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic            aw_fire, w_fire, ar_fire;
  logic [AW-1:0]   c_addr, widx, ridx;
  logic [W-1:0]    c_wdata;
  logic [W/8-1:0]  c_wstrb;

  assign s_axi_bvalid    = (wr_state_q == W_RESP);
  assign s_axi_rvalid    = (rd_state_q == R_DATA);
  assign s_axi_awready   = init_q && !aw_held_q && !s_axi_bvalid;
  assign s_axi_wready    = init_q && !w_held_q && !s_axi_bvalid;
  assign s_axi_arready   = init_q && (rd_state_q == R_IDLE);
  assign s_axi_bresp     = bresp_q;
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = rresp_q;
  assign params_from_bus = regs_q;
  assign wr_pulse        = wr_pulse_q;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;

  // A channel arriving this cycle is used directly, so same-cycle AW+W commits at once.
  assign c_addr  = aw_held_q ? awaddr_q : s_axi_awaddr;
  assign c_wdata = w_held_q ? wdata_q : s_axi_wdata;
  assign c_wstrb = w_held_q ? wstrb_q : s_axi_wstrb;
  assign widx    = c_addr >> ADDR_LSB;
  assign ridx    = s_axi_araddr >> ADDR_LSB;

  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    if (aw_fire) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
    case (wr_state_q)
      W_IDLE: begin
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_RESP;
          bresp_d    = RESP_SLVERR;
          for (int i = 0; i < N_REG; i++) begin
            if (32'(widx) == i) begin
              bresp_d = RESP_OKAY;
              if (!RO_MASK[i]) begin
                regs_d[i*W +: W] = W'(strb_merge(MAX_W'(regs_q[i*W +: W]), MAX_W'(c_wdata),
                                                 (MAX_W/8)'(c_wstrb)));
                wr_pulse_d[i]    = 1'b1;
              end
            end
          end
        end
      end
      W_RESP: if (s_axi_bready) wr_state_d = W_IDLE;
    endcase
  end

  // Read data is sampled from regs_q, so a read racing a commit sees the old value.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rd_state_d = R_DATA;
          rdata_d    = '0;
          rresp_d    = RESP_SLVERR;
          for (int i = 0; i < N_REG; i++) begin
            if (32'(ridx) == i) begin
              rresp_d = RESP_OKAY;
              rdata_d = RO_MASK[i] ? params_to_bus[i*W +: W] : regs_q[i*W +: W];
            end
          end
        end
      end
      R_DATA: if (s_axi_rready) rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      init_q     <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_state_q <= W_IDLE;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      regs_q     <= REG_RESET;
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      init_q     <= 1'b1;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_state_q <= wr_state_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
